// File: rtl/pbit_sample_decoder.sv
// Burn-in, per-bit ones-count accumulation and majority decode of p-bit adder outputs.
// Optional `PBIT_CONSISTENCY_EN adds err_cnt, counting samples where {overflow,sum_out} != a_out+b_out.
module pbit_sample_decoder #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] steps,
   input  logic [CNT_W-1:0] burn_in,
   input  logic [WIDTH-1:0] a_out,
   input  logic [WIDTH-1:0] b_out,
   input  logic [WIDTH-1:0] sum_out,
   input  logic             overflow,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_a,
   output logic [WIDTH-1:0] res_b,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_ovf
`ifdef PBIT_CONSISTENCY_EN
   ,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ACCUM, S_FINISH, S_DONE} state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] steps_q;
   logic [CNT_W-1:0] burn_q;
   logic [CNT_W-1:0] burn_cnt;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] burn_nxt;
   logic [CNT_W-1:0] sample_nxt;
   logic [CNT_W-1:0] cnt_a [WIDTH];
   logic [CNT_W-1:0] cnt_b [WIDTH];
   logic [CNT_W-1:0] cnt_s [WIDTH];
   logic [CNT_W-1:0] cnt_o;

   assign burn_nxt   = burn_cnt + ONE;
   assign sample_nxt = sample_cnt + ONE;

   function automatic logic [CNT_W-1:0] bit_ext(input logic b);
      return {{(CNT_W-1){1'b0}}, b};
   endfunction

   // Strict majority at CNT_W+1 bits: ties and the empty run decode to 0.
   function automatic logic majority(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] n);
      return {cnt, 1'b0} > {1'b0, n};
   endfunction

`ifdef PBIT_CONSISTENCY_EN
   logic [WIDTH:0] exp_sum;
   logic           sample_bad;
   assign exp_sum    = {1'b0, a_out} + {1'b0, b_out};
   assign sample_bad = ({overflow, sum_out} != exp_sum);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         steps_q    <= '0;
         burn_q     <= '0;
         burn_cnt   <= '0;
         sample_cnt <= '0;
         cnt_o      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         res_a      <= '0;
         res_b      <= '0;
         res_sum    <= '0;
         res_ovf    <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_a[i] <= '0;
            cnt_b[i] <= '0;
            cnt_s[i] <= '0;
         end
`ifdef PBIT_CONSISTENCY_EN
         err_cnt    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  steps_q    <= steps;
                  burn_q     <= burn_in;
                  burn_cnt   <= '0;
                  sample_cnt <= '0;
                  cnt_o      <= '0;
                  for (int i = 0; i < WIDTH; i++) begin
                     cnt_a[i] <= '0;
                     cnt_b[i] <= '0;
                     cnt_s[i] <= '0;
                  end
`ifdef PBIT_CONSISTENCY_EN
                  err_cnt    <= '0;
`endif
                  done <= 1'b0;
                  busy <= 1'b1;
                  if (steps == '0)
                     state <= S_FINISH;
                  else if (burn_in != '0)
                     state <= S_SETTLE;
                  else
                     state <= S_ACCUM;
               end
            end
            S_SETTLE: begin
               burn_cnt <= burn_nxt;
               if (burn_nxt == burn_q)
                  state <= S_ACCUM;
            end
            S_ACCUM: begin
               for (int i = 0; i < WIDTH; i++) begin
                  cnt_a[i] <= cnt_a[i] + bit_ext(a_out[i]);
                  cnt_b[i] <= cnt_b[i] + bit_ext(b_out[i]);
                  cnt_s[i] <= cnt_s[i] + bit_ext(sum_out[i]);
               end
               cnt_o <= cnt_o + bit_ext(overflow);
`ifdef PBIT_CONSISTENCY_EN
               err_cnt <= err_cnt + bit_ext(sample_bad);
`endif
               sample_cnt <= sample_nxt;
               if (sample_nxt == steps_q)
                  state <= S_FINISH;
            end
            S_FINISH: begin
               for (int i = 0; i < WIDTH; i++) begin
                  res_a[i]   <= majority(cnt_a[i], steps_q);
                  res_b[i]   <= majority(cnt_b[i], steps_q);
                  res_sum[i] <= majority(cnt_s[i], steps_q);
               end
               res_ovf <= majority(cnt_o, steps_q);
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= S_DONE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
